reg_file_scb: RTL and testbench
===============================

Name: reg_file_scb

Overview:
Parametrised successor to the 16-bit processor's 8-entry register file. Adds the following:
- configurable width and depth
- registered read ports with write-through bypass
- optional hardwired zero register
- a per-register pending (scoreboard) bit that the decode stage sets on issue and the writeback clears

It sits between decode (selA/selB, issue) and writeback (selD/dataD/we).

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 8, number of registers; must be >= 2 and <= 2**SEL_W
SEL_W, 3, register select width
ZERO_REG, 0, 1 = register 0 always reads 0; writes and issues to it are ignored
BYPASS, 1, 1 = a same-cycle write to the read register is forwarded to the read output

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  global enable; when 0, no state or output changes
we  in  1  write enable (qualified by en)
selD  in  SEL_W  write register select
dataD  in  DATA_W  write data
selA  in  SEL_W  read port A select
selB  in  SEL_W  read port B select
issue  in  1  set pending bit of issue_sel (qualified by en)
issue_sel  in  SEL_W  register to mark pending
dataA  out  DATA_W  registered read data, port A
dataB  out  DATA_W  registered read data, port B
busyA  out  1  registered pending flag of selA
busyB  out  1  registered pending flag of selB
pend_any  out  1  registered OR of all pending bits

Behaviour:
- Reset:
  - rst=1 clears, immediately and independent of clk, all registers, all pending bits, dataA, dataB, busyA, busyB and pend_any to 0.
  - Reset asserted mid-operation discards any in-flight write or issue.
- en=0: registers, pending bits and all outputs hold; we and issue are ignored.
- Write: on a rising edge with en=1, we=1 and selD < NUM_REGS (and selD != 0 when ZERO_REG=1), reg[selD] <= dataD.
- Read latency is 1 cycle. On a rising edge with en=1:
  - dataA <= value of reg[selA] after this edge's write, when BYPASS=1;
  - dataA <= value before the write, when BYPASS=0;
  - dataB follows the same rule for selB.
- Out of range: sel >= NUM_REGS reads 0 with busy 0. Writes and issues to such an index are ignored.
- ZERO_REG=1: reads of register 0 return 0 and busy 0.
- Pending bits, per register i, on an en=1 edge:
  - set if issue=1 and issue_sel=i;
  - else cleared if a write to i occurs;
  - else hold.
  - Simultaneous issue and write to the same register: the register takes dataD and the pending bit stays 1, because a newer producer is outstanding.
- busyA/busyB/pend_any are registered from the post-edge pending state, so they stay consistent with dataA/dataB.
  - With BYPASS=0, busyA reflects the post-edge pending state regardless.
- Both read ports may select the same register, and either may equal selD. There is no conflict; each port resolves independently.
- No handshake stalls: the block accepts one write and one issue every enabled cycle.

Test Plan:
1. Reset then write: assert rst for 2 cycles. Then en=1, we=1, selD=1, dataD=16'hFFFF; next cycle we=0, selA=1 -> dataA=16'hFFFF one edge later, busyA=0. dataB=0 for selB=2.
2. Bypass: en=1, we=1, selD=2, dataD=16'h2222, selA=2 in the same cycle -> dataA=16'h2222 after that single edge. Repeat with BYPASS=0 -> dataA shows the old value 0, then 16'h2222 one edge later.
3. en gating: en=0, we=1, selD=4, dataD=16'h4444 for 3 cycles -> reg4 unchanged (0) and outputs hold. Raise en -> reg4=16'h4444; selA=selB=4 -> dataA=dataB=16'h4444.
4. Scoreboard: issue=1, issue_sel=3 -> busyA=1 (selA=3) and pend_any=1. Write selD=3, dataD=16'h3333 -> busyA=0, dataA=16'h3333, pend_any=0. Then issue and write to reg 5 in the same cycle -> reg5 updated and busy stays 1.
5. ZERO_REG=1: write selD=0, dataD=16'hFEED; issue_sel=0 -> dataA for selA=0 reads 0, busyA=0, pend_any unchanged.
6. Async reset mid-op: regs 1–3 loaded and reg 3 pending; pulse rst between edges -> all outputs 0 before the next edge, and all registers read 0 afterwards.

Source files
------------

// File: rtl/reg_file_scb.sv
// Parametrised register file with registered read ports, optional write-through
// bypass, optional hardwired zero register and a per-register pending scoreboard.
module reg_file_scb #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = 3,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [SEL_W-1:0]  selD,
   input  logic [DATA_W-1:0] dataD,
   input  logic [SEL_W-1:0]  selA,
   input  logic [SEL_W-1:0]  selB,
   input  logic              issue,
   input  logic [SEL_W-1:0]  issue_sel,
   output logic [DATA_W-1:0] dataA,
   output logic [DATA_W-1:0] dataB,
   output logic              busyA,
   output logic              busyB,
   output logic              pend_any
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic [DATA_W-1:0]   dataA_q, dataA_d, dataB_q, dataB_d;
   logic                busyA_q, busyA_d, busyB_q, busyB_d;
   logic                pend_any_q, pend_any_d;

   // Register 0 is excluded from writes, issues and reads when it is hardwired.
   function automatic logic is_live(input int idx);
      return !(ZERO_REG != 0 && idx == 0);
   endfunction

   // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
   always_comb begin
      regs_d     = regs_q;
      pend_d     = pend_q;
      dataA_d    = dataA_q;
      dataB_d    = dataB_q;
      busyA_d    = busyA_q;
      busyB_d    = busyB_q;
      pend_any_d = pend_any_q;
      if (en) begin
         // Issue wins over a same-cycle write: a newer producer is still outstanding.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (is_live(i)) begin
               if (we && selD == SEL_W'(i)) regs_d[i] = dataD;
               if (issue && issue_sel == SEL_W'(i))   pend_d[i] = 1'b1;
               else if (we && selD == SEL_W'(i))      pend_d[i] = 1'b0;
            end
         end
         // Selects that match no live register read 0 with busy 0.
         dataA_d = '0;
         dataB_d = '0;
         busyA_d = 1'b0;
         busyB_d = 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (is_live(i)) begin
               if (selA == SEL_W'(i)) begin
                  dataA_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
                  busyA_d = pend_d[i];
               end
               if (selB == SEL_W'(i)) begin
                  dataB_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
                  busyB_d = pend_d[i];
               end
            end
         end
         pend_any_d = |pend_d;
      end
   end

   // NOTE: the register array is reset too, since a reset must make every register read 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         pend_q     <= '0;
         dataA_q    <= '0;
         dataB_q    <= '0;
         busyA_q    <= 1'b0;
         busyB_q    <= 1'b0;
         pend_any_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         dataA_q    <= dataA_d;
         dataB_q    <= dataB_d;
         busyA_q    <= busyA_d;
         busyB_q    <= busyB_d;
         pend_any_q <= pend_any_d;
      end
   end

   assign dataA    = dataA_q;
   assign dataB    = dataB_q;
   assign busyA    = busyA_q;
   assign busyB    = busyB_q;
   assign pend_any = pend_any_q;

endmodule

// File: tb/tb_reg_file_scb.sv
// Directed bench for reg_file_scb: three instances share stimulus (default,
// no-bypass, and zero-register with 6 registers) and are checked against hand values.
module tb_reg_file_scb;

   logic        clk = 1'b0;
   logic        rst, en, we, issue;
   logic [2:0]  selD, selA, selB, issue_sel;
   logic [15:0] dataD;

   logic [15:0] a_def, b_def, a_nb, b_nb, a_z, b_z;
   logic        ba_def, bb_def, pa_def, ba_nb, bb_nb, pa_nb, ba_z, bb_z, pa_z;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reg_file_scb dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .selD(selD), .dataD(dataD),
      .selA(selA), .selB(selB), .issue(issue), .issue_sel(issue_sel),
      .dataA(a_def), .dataB(b_def), .busyA(ba_def), .busyB(bb_def), .pend_any(pa_def)
   );

   reg_file_scb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .en(en), .we(we), .selD(selD), .dataD(dataD),
      .selA(selA), .selB(selB), .issue(issue), .issue_sel(issue_sel),
      .dataA(a_nb), .dataB(b_nb), .busyA(ba_nb), .busyB(bb_nb), .pend_any(pa_nb)
   );

   reg_file_scb #(.ZERO_REG(1), .NUM_REGS(6)) dut_z (
      .clk(clk), .rst(rst), .en(en), .we(we), .selD(selD), .dataD(dataD),
      .selA(selA), .selB(selB), .issue(issue), .issue_sel(issue_sel),
      .dataA(a_z), .dataB(b_z), .busyA(ba_z), .busyB(bb_z), .pend_any(pa_z)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; we = 1'b0; issue = 1'b0;
      selD = '0; selA = '0; selB = '0; issue_sel = '0; dataD = '0;

      // Reset then write
      repeat (2) step();
      check("rst_dataA", a_def, 0);
      check("rst_busyA", ba_def, 0);
      check("rst_pend_any", pa_def, 0);
      rst = 1'b0;
      en = 1'b1; we = 1'b1; selD = 3'd1; dataD = 16'hFFFF; selA = 3'd0; selB = 3'd2;
      step();
      we = 1'b0; selA = 3'd1;
      step();
      check("wr_dataA", a_def, 16'hFFFF);
      check("wr_busyA", ba_def, 0);
      check("wr_dataB", b_def, 0);
      check("wr_nb_dataA", a_nb, 16'hFFFF);

      // Bypass versus no bypass
      we = 1'b1; selD = 3'd2; dataD = 16'h2222; selA = 3'd2;
      step();
      check("byp_dataA", a_def, 16'h2222);
      check("nobyp_old", a_nb, 0);
      we = 1'b0;
      step();
      check("nobyp_new", a_nb, 16'h2222);

      // Enable gating
      en = 1'b0; we = 1'b1; selD = 3'd4; dataD = 16'h4444; selA = 3'd4; selB = 3'd4;
      repeat (3) step();
      check("en0_holdA", a_def, 16'h2222);
      check("en0_holdB", b_def, 16'h2222);
      en = 1'b1;
      step();
      check("en1_dataA", a_def, 16'h4444);
      check("en1_dataB", b_def, 16'h4444);
      check("en1_nb_reg4_old", a_nb, 0);
      we = 1'b0;
      step();
      check("en1_nb_reg4_new", a_nb, 16'h4444);

      // Scoreboard
      issue = 1'b1; issue_sel = 3'd3; selA = 3'd3; selB = 3'd5;
      step();
      check("scb_busyA_set", ba_def, 1);
      check("scb_pend_any_set", pa_def, 1);
      check("scb_busyB_idle", bb_def, 0);
      issue = 1'b0; we = 1'b1; selD = 3'd3; dataD = 16'h3333;
      step();
      check("scb_busyA_clr", ba_def, 0);
      check("scb_dataA", a_def, 16'h3333);
      check("scb_pend_any_clr", pa_def, 0);
      issue = 1'b1; issue_sel = 3'd5; selD = 3'd5; dataD = 16'h5555; selA = 3'd5;
      step();
      check("scb_same_data", a_def, 16'h5555);
      check("scb_same_busy", ba_def, 1);
      check("scb_same_pend", pa_def, 1);

      // Out of range on the 6-register instance
      issue = 1'b0; we = 1'b1; selD = 3'd7; dataD = 16'h7777; selA = 3'd7;
      step();
      check("oor_def_dataA", a_def, 16'h7777);
      check("oor_z_dataA", a_z, 0);
      check("oor_z_busyA", ba_z, 0);
      check("oor_z_pend", pa_z, 1);

      // Hardwired zero register
      we = 1'b1; selD = 3'd0; dataD = 16'hFEED; issue = 1'b1; issue_sel = 3'd0;
      selA = 3'd0; selB = 3'd5;
      step();
      check("zero_dataA", a_z, 0);
      check("zero_busyA", ba_z, 0);
      check("zero_pend_any", pa_z, 1);
      check("zero_dataB", b_z, 16'h5555);
      check("zero_busyB", bb_z, 1);
      check("r0_def_dataA", a_def, 16'hFEED);
      check("r0_def_busyA", ba_def, 1);
      we = 1'b0; issue_sel = 3'd6; selA = 3'd6;
      step();
      check("oor_issue_def", ba_def, 1);
      check("oor_issue_z", ba_z, 0);

      // Asynchronous reset mid-operation
      issue = 1'b1; issue_sel = 3'd3; selA = 3'd3; selB = 3'd1;
      step();
      check("pre_rst_dataA", a_def, 16'h3333);
      check("pre_rst_busyA", ba_def, 1);
      check("pre_rst_dataB", b_def, 16'hFFFF);
      issue = 1'b0; we = 1'b1; selD = 3'd1; dataD = 16'hAAAA;
      #2 rst = 1'b1;
      #1;
      check("arst_dataA", a_def, 0);
      check("arst_dataB", b_def, 0);
      check("arst_busyA", ba_def, 0);
      check("arst_pend_any", pa_def, 0);
      #1 rst = 1'b0;
      we = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         selA = 3'(i); selB = 3'(i);
         step();
         check($sformatf("post_rst_r%0d_A", i), a_def, 0);
         check($sformatf("post_rst_r%0d_B", i), b_def, 0);
         check($sformatf("post_rst_r%0d_busy", i), ba_def, 0);
      end
      check("post_rst_pend_any", pa_def, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
